pixel_fifo_writer: RTL

Raster-order pixel producer that fills the display pixel FIFO consumed by the VGA pixel-output logic. It keeps its own x/y counters for one active frame, generates 24-bit RGB from a selectable test pattern, and writes one pixel per cycle whenever the FIFO has room. It aligns to the display side through a frame-sync pulse, so the FIFO holds pixel (0,0) first for every frame.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/pixel_fifo_writer_if.sv | 11 +
 rtl/pixel_fifo_writer_pattern_gen.sv | 51 +++++
 rtl/pixel_fifo_writer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared display-side definitions: frame geometry defaults, pattern codes,
// writer state encoding and RGB field widths.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT  = 640;
  localparam int V_ACTIVE_DEFAULT  = 480;
  localparam int BAR_W_DEFAULT     = 80;
  localparam int CHK_SHIFT_DEFAULT = 5;

  localparam int COLOR_W = 8;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_FILL      = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Assemble a {r, g, b} pixel word from its three channels.
  function automatic logic [RGB_W-1:0] pack_rgb(input logic [COLOR_W-1:0] r,
                                                input logic [COLOR_W-1:0] g,
                                                input logic [COLOR_W-1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/pixel_fifo_writer_if.sv
// Write side of the display pixel FIFO: strobe, pixel word and full flag.
interface pixel_fifo_writer_if;
  import vga_pkg::*;

  logic             fifo_wr_en;
  logic [RGB_W-1:0] fifo_wr_data;
  logic             fifo_full;

  modport master (output fifo_wr_en, output fifo_wr_data, input fifo_full);
  modport slave  (input fifo_wr_en, input fifo_wr_data, output fifo_full);
endinterface

// File: rtl/pixel_fifo_writer_pattern_gen.sv
// Combinational test-pattern generator: (x, y, pattern, solid) -> pixel.
// Kept free of state so the display side can reuse it as a reference.
module pattern_gen
  import vga_pkg::*;
#(
  parameter int BAR_W     = BAR_W_DEFAULT,
  parameter int CHK_SHIFT = CHK_SHIFT_DEFAULT
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  pattern_e           pattern,
  input  logic [RGB_W-1:0]   solid_rgb,
  output logic [RGB_W-1:0]   rgb
);

  logic [COORD_W-1:0] bar_quot_s;
  logic [2:0]         bar_idx_s;
  logic [COLOR_W-1:0] r_bar_s;
  logic [COLOR_W-1:0] g_bar_s;
  logic [COLOR_W-1:0] b_bar_s;
  logic               chk_white_s;
  logic               unused_y_s;

  assign bar_quot_s  = x / COORD_W'(BAR_W);
  assign bar_idx_s   = bar_quot_s[2:0];
  // Bar index bits are inverted so bar 0 is white and bar 7 is black.
  assign r_bar_s     = bar_idx_s[2] ? 8'h00 : 8'hFF;
  assign g_bar_s     = bar_idx_s[1] ? 8'h00 : 8'hFF;
  assign b_bar_s     = bar_idx_s[0] ? 8'h00 : 8'hFF;
  assign chk_white_s = x[CHK_SHIFT] ^ y[CHK_SHIFT];
  assign unused_y_s  = ^y;

  // Select the pixel colour for the requested pattern.
  always_comb begin
    rgb = {RGB_W{1'b0}};
    case (pattern)
      PAT_BARS:  rgb = pack_rgb(r_bar_s, g_bar_s, b_bar_s);
      PAT_CHECK: begin
        if (chk_white_s) begin
          rgb = {RGB_W{1'b1}};
        end else begin
          rgb = {RGB_W{1'b0}};
        end
      end
      PAT_RAMP:  rgb = pack_rgb(x[9:2], x[9:2], x[9:2]);
      PAT_SOLID: rgb = solid_rgb;
      default:   rgb = {RGB_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/pixel_fifo_writer.sv
// Raster-order pixel producer feeding the display pixel FIFO. Tracks x/y of
// one active frame, aligns to the display through frame_sync and writes one
// pixel per cycle whenever the FIFO has room.
module pixel_fifo_writer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE  = V_ACTIVE_DEFAULT,
  parameter int BAR_W     = BAR_W_DEFAULT,
  parameter int CHK_SHIFT = CHK_SHIFT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                frame_sync,
  input  logic [1:0]          pattern_sel,
  input  logic [RGB_W-1:0]    solid_rgb,
  pixel_fifo_writer_if.master fifo,
  output logic                frame_done,
  output logic                resync_err
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  pattern_e           pattern_q, pattern_d;
  logic [RGB_W-1:0]   solid_q, solid_d;
  logic               frame_done_q, frame_done_d;
  logic               resync_err_q, resync_err_d;

  logic               wr_en_s;
  logic               last_px_s;
  logic [RGB_W-1:0]   pix_s;

  pattern_gen #(
    .BAR_W     (BAR_W),
    .CHK_SHIFT (CHK_SHIFT)
  ) u_pattern_gen (
    .x         (x_q),
    .y         (y_q),
    .pattern   (pattern_q),
    .solid_rgb (solid_q),
    .rgb       (pix_s)
  );

  assign last_px_s = (x_q == X_LAST) && (y_q == Y_LAST);

  // Write strobe: only while filling, enabled and the FIFO has room.
  always_comb begin
    wr_en_s = 1'b0;
    if ((state_q == ST_FILL) && enable && !fifo.fifo_full) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  assign fifo.fifo_wr_en   = wr_en_s;
  assign fifo.fifo_wr_data = (state_q == ST_FILL) ? pix_s : {RGB_W{1'b0}};
  assign frame_done        = frame_done_q;
  assign resync_err        = resync_err_q;

  // Next-state, counter, pattern-latch and pulse logic.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pattern_d    = pattern_q;
    solid_d      = solid_q;
    frame_done_d = 1'b0;
    resync_err_d = 1'b0;

    if (!enable) begin
      // Disable wins over everything, including a pending frame_sync.
      state_d = ST_IDLE;
      x_d     = {COORD_W{1'b0}};
      y_d     = {COORD_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC, ST_DONE: begin
          if (frame_sync) begin
            state_d   = ST_FILL;
            x_d       = {COORD_W{1'b0}};
            y_d       = {COORD_W{1'b0}};
            pattern_d = pattern_e'(pattern_sel);
            solid_d   = solid_rgb;
          end else begin
            state_d = state_q;
          end
        end
        ST_FILL: begin
          if (wr_en_s && last_px_s) begin
            // Frame completed; a coincident sync is a clean restart, not an error.
            frame_done_d = 1'b1;
            x_d          = {COORD_W{1'b0}};
            y_d          = {COORD_W{1'b0}};
            if (frame_sync) begin
              state_d   = ST_FILL;
              pattern_d = pattern_e'(pattern_sel);
              solid_d   = solid_rgb;
            end else begin
              state_d = ST_DONE;
            end
          end else if (frame_sync) begin
            // Mid-frame sync: abandon the partial frame and restart at (0,0).
            resync_err_d = 1'b1;
            x_d          = {COORD_W{1'b0}};
            y_d          = {COORD_W{1'b0}};
            pattern_d    = pattern_e'(pattern_sel);
            solid_d      = solid_rgb;
          end else if (wr_en_s) begin
            if (x_q == X_LAST) begin
              x_d = {COORD_W{1'b0}};
              y_d = y_q + 10'd1;
            end else begin
              x_d = x_q + 10'd1;
            end
          end else begin
            x_d = x_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, latched pattern and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      x_q          <= {COORD_W{1'b0}};
      y_q          <= {COORD_W{1'b0}};
      pattern_q    <= PAT_BARS;
      solid_q      <= {RGB_W{1'b0}};
      frame_done_q <= 1'b0;
      resync_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pattern_q    <= pattern_d;
      solid_q      <= solid_d;
      frame_done_q <= frame_done_d;
      resync_err_q <= resync_err_d;
    end
  end

endmodule
